// File: rtl/voice_mixer.sv
// voice_mixer: snapshots NUM_VOICES signed voices on a tick, sums enabled ones one per clock, scales, saturates and hands off.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int VOL_SHIFT  = 7
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    sample_tick,
  input  logic [16*NUM_VOICES-1:0] voices_in,
  input  logic [NUM_VOICES-1:0]   voice_en,
  input  logic [7:0]              volume,
  output logic [15:0]             out_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    clip,
  output logic                    overrun,
  input  logic                    clr_status
);
  localparam int AW = 16 + $clog2(NUM_VOICES);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int PW = AW + 9;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
  state_t                  state_q;
  logic [16*NUM_VOICES-1:0] snap_v_q;
  logic [NUM_VOICES-1:0]   snap_en_q;
  logic [7:0]              snap_vol_q;
  logic signed [AW-1:0]    acc_q;
  logic [IW-1:0]           idx_q;
  logic [15:0]             res_q, out_sample_q;
  logic                    pend_q, out_valid_q, clip_q, ovr_q;
  logic                    clip_d, ovr_d;
  logic signed [15:0]      cur_v;
  logic signed [AW-1:0]    cur_ext;
  logic signed [PW-1:0]    prod, shifted;
  logic                    sat_hi, sat_lo;
  logic [15:0]             sat_res;
  always_comb begin
    cur_v   = snap_v_q[16*idx_q +: 16];
    cur_ext = AW'(cur_v);
    prod    = acc_q * $signed({1'b0, snap_vol_q});
    shifted = prod >>> VOL_SHIFT;
    sat_hi  = shifted > PW'(32767);
    sat_lo  = shifted < PW'(-32768);
    sat_res = sat_hi ? 16'h7fff : sat_lo ? 16'h8000 : shifted[15:0];
    clip_d  = (clip_q && !clr_status) || (state_q == SCALE && (sat_hi || sat_lo));
    // a result landing on an unaccepted one, or a tick arriving mid-mix, is an overrun
    ovr_d   = (ovr_q && !clr_status) || (sample_tick && state_q != IDLE) ||
              (pend_q && out_valid_q && !out_ready);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      snap_v_q     <= '0;
      snap_en_q    <= '0;
      snap_vol_q   <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      res_q        <= '0;
      pend_q       <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      clip_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      clip_q <= clip_d;
      ovr_q  <= ovr_d;
      pend_q <= state_q == SCALE;
      if (pend_q) begin
        out_sample_q <= res_q;
        out_valid_q  <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (sample_tick) begin
          snap_v_q   <= voices_in;
          snap_en_q  <= voice_en;
          snap_vol_q <= volume;
          acc_q      <= '0;
          idx_q      <= '0;
          state_q    <= ACCUM;
        end
        ACCUM: begin
          if (snap_en_q[idx_q]) acc_q <= acc_q + cur_ext;
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(NUM_VOICES - 1)) state_q <= SCALE;
        end
        SCALE: begin
          res_q   <= sat_res;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign busy       = state_q != IDLE;
  assign clip       = clip_q;
  assign overrun    = ovr_q;
endmodule
